alu_regfile_pipe: RTL and testbench

Parametrised two-stage ALU/register-file datapath. It is the successor to the combinational 8-bit, 8-register, 4-op ALU/register-file pair. Adds a valid/ready instruction stream, a registered result stream with backpressure, eight operations including add/sub/load-immediate, zero/carry flags, and write-back forwarding. It sits between an instruction sequencer and any result consumer.

---
 rtl/alu_regfile_pipe.sv | 152 +++++++++++++++
 tb/tb_alu_regfile_pipe.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_regfile_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_regfile_pipe: two-stage ALU / register-file datapath with valid/ready |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module alu_regfile_pipe #(
  parameter  int WIDTH = 8,
  parameter  int NREGS = 8,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [AW-1:0]    in_rs1,
  input  logic [AW-1:0]    in_rs2,
  input  logic [AW-1:0]    in_rd,
  input  logic             in_we,
  input  logic [WIDTH-1:0] in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_carry,
  output logic [AW-1:0]    out_rd
);

  localparam logic [2:0] c_OP_AND  = 3'b000;
  localparam logic [2:0] c_OP_OR   = 3'b001;
  localparam logic [2:0] c_OP_NAND = 3'b010;
  localparam logic [2:0] c_OP_NOR  = 3'b011;
  localparam logic [2:0] c_OP_XOR  = 3'b100;
  localparam logic [2:0] c_OP_ADD  = 3'b101;
  localparam logic [2:0] c_OP_SUB  = 3'b110;
  localparam logic [2:0] c_OP_LDI  = 3'b111;

  logic [WIDTH-1:0] r_regs [NREGS];

  logic             r_a_valid;
  logic [2:0]       r_a_op;
  logic [AW-1:0]    r_a_rs1;
  logic [AW-1:0]    r_a_rs2;
  logic [AW-1:0]    r_a_rd;
  logic             r_a_we;
  logic [WIDTH-1:0] r_a_imm;

  logic             r_b_valid;
  logic [WIDTH-1:0] r_b_result;
  logic             r_b_zero;
  logic             r_b_carry;
  logic [AW-1:0]    r_b_rd;
  logic             r_b_we;

  logic             w_b_leave;
  logic             w_a_adv;
  logic             w_fwd1;
  logic             w_fwd2;
  logic [WIDTH-1:0] w_opa;
  logic [WIDTH-1:0] w_opb;
  logic [WIDTH:0]   w_alu;
  logic             w_zero;

  assign w_b_leave = r_b_valid && out_ready;
  assign w_a_adv   = r_a_valid && (!r_b_valid || w_b_leave);
  assign in_ready  = !r_a_valid || w_a_adv;

  // The retiring result is written on the same edge the operands are consumed,
  // so bypass it around the register file.
  assign w_fwd1 = w_b_leave && r_b_we && (r_b_rd == r_a_rs1);
  assign w_fwd2 = w_b_leave && r_b_we && (r_b_rd == r_a_rs2);
  assign w_opa  = w_fwd1 ? r_b_result : r_regs[r_a_rs1];
  assign w_opb  = w_fwd2 ? r_b_result : r_regs[r_a_rs2];

  // Bit WIDTH carries the ADD carry-out or the SUB borrow; zero for other ops.
  always_comb begin
    w_alu = '0;
    case (r_a_op)
      c_OP_AND:  w_alu = {1'b0, w_opa & w_opb};
      c_OP_OR:   w_alu = {1'b0, w_opa | w_opb};
      c_OP_NAND: w_alu = {1'b0, ~(w_opa & w_opb)};
      c_OP_NOR:  w_alu = {1'b0, ~(w_opa | w_opb)};
      c_OP_XOR:  w_alu = {1'b0, w_opa ^ w_opb};
      c_OP_ADD:  w_alu = {1'b0, w_opa} + {1'b0, w_opb};
      c_OP_SUB:  w_alu = {1'b0, w_opa} - {1'b0, w_opb};
      c_OP_LDI:  w_alu = {1'b0, r_a_imm};
      default:   w_alu = '0;
    endcase
  end

  assign w_zero = (w_alu[WIDTH-1:0] == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_valid <= 1'b0;
      r_a_op    <= '0;
      r_a_rs1   <= '0;
      r_a_rs2   <= '0;
      r_a_rd    <= '0;
      r_a_we    <= 1'b0;
      r_a_imm   <= '0;
    end else if (in_ready) begin
      r_a_valid <= in_valid;
      if (in_valid) begin
        r_a_op  <= in_op;
        r_a_rs1 <= in_rs1;
        r_a_rs2 <= in_rs2;
        r_a_rd  <= in_rd;
        r_a_we  <= in_we;
        r_a_imm <= in_imm;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_b_valid  <= 1'b0;
      r_b_result <= '0;
      r_b_zero   <= 1'b0;
      r_b_carry  <= 1'b0;
      r_b_rd     <= '0;
      r_b_we     <= 1'b0;
    end else if (w_a_adv) begin
      r_b_valid  <= 1'b1;
      r_b_result <= w_alu[WIDTH-1:0];
      r_b_zero   <= w_zero;
      r_b_carry  <= w_alu[WIDTH];
      r_b_rd     <= r_a_rd;
      r_b_we     <= r_a_we;
    end else if (w_b_leave) begin
      r_b_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_b_leave && r_b_we) begin
      r_regs[r_b_rd] <= r_b_result;
    end
  end

  assign out_valid  = r_b_valid;
  assign out_result = r_b_result;
  assign out_zero   = r_b_zero;
  assign out_carry  = r_b_carry;
  assign out_rd     = r_b_rd;

endmodule
`default_nettype wire

// File: tb/tb_alu_regfile_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_alu_regfile_pipe: self-checking bench for alu_regfile_pipe            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_alu_regfile_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid, in_ready, in_we, out_valid, out_ready, out_zero, out_carry;
  logic [2:0] in_op, in_rs1, in_rs2, in_rd, out_rd;
  logic [7:0] in_imm, out_result;

  logic        v16_in_valid, v16_in_ready, v16_in_we, v16_out_valid, v16_out_ready;
  logic        v16_out_zero, v16_out_carry;
  logic [2:0]  v16_in_op;
  logic [3:0]  v16_in_rs1, v16_in_rs2, v16_in_rd, v16_out_rd;
  logic [15:0] v16_in_imm, v16_out_result;

  alu_regfile_pipe #(.WIDTH(8), .NREGS(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_we(in_we), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_carry(out_carry), .out_rd(out_rd)
  );

  alu_regfile_pipe #(.WIDTH(16), .NREGS(16)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(v16_in_valid), .in_ready(v16_in_ready), .in_op(v16_in_op),
    .in_rs1(v16_in_rs1), .in_rs2(v16_in_rs2), .in_rd(v16_in_rd), .in_we(v16_in_we),
    .in_imm(v16_in_imm),
    .out_valid(v16_out_valid), .out_ready(v16_out_ready), .out_result(v16_out_result),
    .out_zero(v16_out_zero), .out_carry(v16_out_carry), .out_rd(v16_out_rd)
  );

  typedef struct {
    logic [2:0] op;
    logic [2:0] rs1, rs2, rd;
    logic       we;
    logic [7:0] imm;
    logic [7:0] res;
    logic       z, c;
  } vec_t;

  typedef struct {
    logic [7:0] res;
    logic       z, c;
    logic [2:0] rd;
  } exp_t;

  exp_t       q[$];
  logic [7:0] mregs [8];
  int         n_vec = 0;
  int         n_err = 0;
  bit         rnd_on = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out", nm);
  endtask

  // Architectural reference: instructions take effect in program order.
  function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input logic [7:0] imm, input logic [2:0] rd);
    exp_t        e;
    int unsigned ai, bi, r;
    bit          c;
    ai = a; bi = b; c = 0; r = 0;
    case (op)
      3'd0: r = ai & bi;
      3'd1: r = ai | bi;
      3'd2: r = ~(ai & bi) & 32'hFF;
      3'd3: r = ~(ai | bi) & 32'hFF;
      3'd4: r = ai ^ bi;
      3'd5: begin r = ai + bi; c = (r > 255); r = r % 256; end
      3'd6: begin c = (ai < bi); r = (ai + 256 - bi) % 256; end
      default: r = imm;
    endcase
    e.res = r[7:0];
    e.z   = (r[7:0] == 8'h00);
    e.c   = c;
    e.rd  = rd;
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue_e(input vec_t v, input exp_t e);
    bit acc;
    int k;
    q.push_back(e);
    if (v.we) mregs[v.rd] = e.res;
    in_valid = 1'b1; in_op = v.op; in_rs1 = v.rs1; in_rs2 = v.rs2;
    in_rd = v.rd; in_we = v.we; in_imm = v.imm;
    acc = 0; k = 0;
    while (!acc && k < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      k++;
    end
    if (!acc) timeout_fail("accept");
    in_valid = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] rs1, input logic [2:0] rs2,
                       input logic [2:0] rd, input logic we, input logic [7:0] imm);
    vec_t v;
    v.op = op; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.we = we; v.imm = imm;
    v.res = '0; v.z = 0; v.c = 0;
    issue_e(v, model(op, mregs[rs1], mregs[rs2], imm, rd));
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 500) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (q.size() != 0) timeout_fail("drain");
  endtask

  task automatic read_all();
    for (int i = 0; i < 8; i++) issue(3'd1, 3'(i), 3'(i), 3'(i), 1'b0, 8'h00);
    drain();
  endtask

  // Retirement scoreboard and hold-stability check.
  logic       held_v = 0;
  logic [7:0] held_res;
  logic       held_z, held_c;
  logic [2:0] held_rd;
  always @(negedge clk) begin
    if (rst) begin
      held_v = 0;
    end else begin
      if (held_v && out_valid) begin
        chk("hold_result", out_result, held_res);
        chk("hold_rd", out_rd, held_rd);
        chk("hold_flags", {out_zero, out_carry}, {held_z, held_c});
      end
      held_v = out_valid && !out_ready;
      held_res = out_result; held_z = out_zero; held_c = out_carry; held_rd = out_rd;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_retire", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("result", out_result, e.res);
          chk("zero", out_zero, e.z);
          chk("carry", out_carry, e.c);
          chk("rd", out_rd, e.rd);
        end
      end
    end
  end

  vec_t tbl [13];

  initial begin
    tbl[0]  = '{3'd0, 3'd0, 3'd1, 3'd0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0};
    tbl[1]  = '{3'd7, 3'd0, 3'd0, 3'd1, 1'b1, 8'hC8, 8'hC8, 1'b0, 1'b0};
    tbl[2]  = '{3'd7, 3'd0, 3'd0, 3'd2, 1'b1, 8'h64, 8'h64, 1'b0, 1'b0};
    tbl[3]  = '{3'd5, 3'd1, 3'd2, 3'd3, 1'b1, 8'h00, 8'h2C, 1'b0, 1'b1};
    tbl[4]  = '{3'd6, 3'd2, 3'd1, 3'd4, 1'b1, 8'h00, 8'h9C, 1'b0, 1'b1};
    tbl[5]  = '{3'd6, 3'd1, 3'd1, 3'd5, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0};
    tbl[6]  = '{3'd7, 3'd0, 3'd0, 3'd1, 1'b1, 8'hF0, 8'hF0, 1'b0, 1'b0};
    tbl[7]  = '{3'd7, 3'd0, 3'd0, 3'd2, 1'b1, 8'h3C, 8'h3C, 1'b0, 1'b0};
    tbl[8]  = '{3'd0, 3'd1, 3'd2, 3'd6, 1'b1, 8'h00, 8'h30, 1'b0, 1'b0};
    tbl[9]  = '{3'd1, 3'd1, 3'd2, 3'd6, 1'b1, 8'h00, 8'hFC, 1'b0, 1'b0};
    tbl[10] = '{3'd2, 3'd1, 3'd2, 3'd6, 1'b1, 8'h00, 8'hCF, 1'b0, 1'b0};
    tbl[11] = '{3'd3, 3'd1, 3'd2, 3'd6, 1'b1, 8'h00, 8'h03, 1'b0, 1'b0};
    tbl[12] = '{3'd4, 3'd1, 3'd2, 3'd7, 1'b1, 8'h00, 8'hCC, 1'b0, 1'b0};

    rst = 1; in_valid = 0; in_op = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_we = 0;
    in_imm = 0; out_ready = 1;
    v16_in_valid = 0; v16_in_op = 0; v16_in_rs1 = 0; v16_in_rs2 = 0; v16_in_rd = 0;
    v16_in_we = 0; v16_in_imm = 0; v16_out_ready = 1;
    for (int i = 0; i < 8; i++) mregs[i] = 8'h00;

    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_result", out_result, 0);
    chk("reset_flags_rd", {out_zero, out_carry, out_rd}, 0);
    @(posedge clk);
    #1;

    // Back-to-back table stream, one result per cycle.
    for (int i = 0; i < 13; i++) begin
      exp_t e;
      e.res = tbl[i].res; e.z = tbl[i].z; e.c = tbl[i].c; e.rd = tbl[i].rd;
      issue_e(tbl[i], e);
    end
    drain();

    // Backpressure: three instructions against a stalled consumer.
    out_ready = 0;
    fork
      begin
        issue(3'd7, 3'd0, 3'd0, 3'd3, 1'b1, 8'h11);
        issue(3'd5, 3'd3, 3'd3, 3'd4, 1'b1, 8'h00);
        issue(3'd6, 3'd4, 3'd3, 3'd5, 1'b1, 8'h00);
      end
      begin
        repeat (4) @(negedge clk);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_out_rd", out_rd, 3);
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1;
      end
    join
    drain();
    read_all();

    // Random stream under random backpressure.
    rnd_on = 1;
    fork
      while (rnd_on) begin
        @(posedge clk);
        #1 out_ready = (($urandom % 4) != 0);
      end
    join_none
    for (int n = 0; n < 300; n++) begin
      if (($urandom % 4) == 0) begin
        @(posedge clk);
        #1;
      end
      issue(3'($urandom % 8), 3'($urandom % 8), 3'($urandom % 8), 3'($urandom % 8),
            1'(($urandom % 4) != 0), 8'($urandom));
    end
    rnd_on = 0;
    @(posedge clk);
    #2 out_ready = 1;
    drain();
    read_all();

    // Reset with both stages occupied.
    out_ready = 0;
    issue(3'd7, 3'd0, 3'd0, 3'd6, 1'b1, 8'hAA);
    issue(3'd7, 3'd0, 3'd0, 3'd7, 1'b1, 8'h55);
    rst = 1;
    out_ready = 1;
    q.delete();
    for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(posedge clk);
    #1 rst = 0;
    read_all();

    // Wide instance: carry out of the top bit and forwarded operand.
    @(posedge clk);
    #1 v16_in_valid = 1; v16_in_op = 3'd7; v16_in_rd = 4'd1; v16_in_we = 1; v16_in_imm = 16'hFFFF;
    @(posedge clk);
    #1 v16_in_rd = 4'd2; v16_in_imm = 16'h0001;
    @(posedge clk);
    #1 v16_in_op = 3'd5; v16_in_rs1 = 4'd1; v16_in_rs2 = 4'd2; v16_in_rd = 4'd3;
    @(negedge clk);
    chk("w16_ldi1", {v16_out_valid, v16_out_result}, {1'b1, 16'hFFFF});
    @(posedge clk);
    #1 v16_in_valid = 0;
    @(negedge clk);
    chk("w16_ldi2", {v16_out_valid, v16_out_result}, {1'b1, 16'h0001});
    @(negedge clk);
    chk("w16_add_result", {v16_out_valid, v16_out_result}, {1'b1, 16'h0000});
    chk("w16_add_flags", {v16_out_zero, v16_out_carry, v16_out_rd}, {1'b1, 1'b1, 4'd3});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
